mcoi_link_reset_sequencer: RTL and testbench



---
 rtl/mcoi_link_reset_sequencer_pkg.sv | 22 ++
 rtl/mcoi_link_reset_sequencer_sync_2ff.sv | 17 +
 rtl/mcoi_link_reset_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_mcoi_link_reset_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcoi_link_reset_sequencer_pkg.sv
// Shared types and defaults for the MCOI GBT link reset sequencer.
package MCPkg;

  // Sequencer states; encodings are visible on state_o and must stay fixed.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_TX_RST    = 3'd2,
    ST_RX_RST    = 3'd3,
    ST_WAIT_RX   = 3'd4,
    ST_UP        = 3'd5
  } link_state_e;

  // Default width of the diagnostic event counters.
  localparam int C_CNT_W = 16;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mcoi_link_reset_sequencer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level. No reset, so the
// chain keeps tracking its input while the sequencer is held in reset.
module mcoi_sync_2ff (
  input  logic clk,
  input  logic d,
  output logic q
);

  logic meta;

  // Capture the async level, then give it a full cycle to settle.
  always_ff @(posedge clk) begin
    meta <= d;
    q    <= meta;
  end

endmodule

// File: rtl/mcoi_link_reset_sequencer.sv
// GBT link bring-up sequencer: waits for a stable PLL lock, pulses the TX
// and RX resets, waits for RX ready and keeps the link up, falling back to
// an RX reset on signal loss and to lock wait on PLL lock loss.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   IDLE      | one cycle after reset release
//   WAIT_LOCK | filtering PLL lock with no LOS for G_LOCK_FILTER cycles
//   TX_RST    | GBT TX reset pulse, G_RST_CYCLES long
//   RX_RST    | GBT RX reset pulse, G_RST_CYCLES long (reloaded per entry)
//   WAIT_RX   | waiting for RX ready, retry RX reset after G_RX_TIMEOUT
//   UP        | link operational, user logic released
module mcoi_link_reset_sequencer
  import MCPkg::*;
#(
  parameter int G_LOCK_FILTER = 1000,
  parameter int G_RST_CYCLES  = 16,
  parameter int G_RX_TIMEOUT  = 100000,
  parameter int G_CNT_W       = C_CNT_W
) (
  input  logic               clk_ik,
  input  logic               rstn_ir,
  input  logic               pll_locked_i,
  input  logic               los_i,
  input  logic               rx_ready_i,
  output logic               gbt_tx_reset_o,
  output logic               gbt_rx_reset_o,
  output logic               user_reset_o,
  output logic               link_up_o,
  output logic [2:0]         state_o,
  output logic [G_CNT_W-1:0] relock_cnt_o,
  output logic [G_CNT_W-1:0] drop_cnt_o,
  output logic [G_CNT_W-1:0] timeout_cnt_o
);

  localparam int FILT_W  = cnt_width(G_LOCK_FILTER);
  localparam int TMR_MAX = (G_RST_CYCLES > G_RX_TIMEOUT) ? G_RST_CYCLES : G_RX_TIMEOUT;
  localparam int TMR_W   = cnt_width(TMR_MAX);

  // Filter counts up to its last qualifying cycle; the pulse/timeout timer
  // is a down-counter loaded with length-1 and terminates at zero.
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(G_LOCK_FILTER - 1);
  localparam logic [TMR_W-1:0]  RST_LOAD  = TMR_W'(G_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMO_LOAD  = TMR_W'(G_RX_TIMEOUT - 1);

  logic lock_s;
  logic los_s;
  logic rdy_s;

  link_state_e         state;
  link_state_e         state_nxt;
  logic [FILT_W-1:0]   filt_cnt;
  logic [FILT_W-1:0]   filt_nxt;
  logic [TMR_W-1:0]    tmr;
  logic [TMR_W-1:0]    tmr_nxt;
  logic [G_CNT_W-1:0]  relock_nxt;
  logic [G_CNT_W-1:0]  drop_nxt;
  logic [G_CNT_W-1:0]  timeout_nxt;
  logic                tx_rst_nxt;
  logic                rx_rst_nxt;
  logic                user_rst_nxt;
  logic                link_up_nxt;

  function automatic logic [G_CNT_W-1:0] sat_inc(input logic [G_CNT_W-1:0] v);
    return (&v) ? v : v + G_CNT_W'(1);
  endfunction

  mcoi_sync_2ff u_sync_lock (
    .clk (clk_ik),
    .d   (pll_locked_i),
    .q   (lock_s)
  );

  mcoi_sync_2ff u_sync_los (
    .clk (clk_ik),
    .d   (los_i),
    .q   (los_s)
  );

  mcoi_sync_2ff u_sync_rdy (
    .clk (clk_ik),
    .d   (rx_ready_i),
    .q   (rdy_s)
  );

  // Next-state, timer reloads, event counting and output decode.
  always_comb begin
    state_nxt   = state;
    filt_nxt    = filt_cnt;
    tmr_nxt     = tmr;
    relock_nxt  = relock_cnt_o;
    drop_nxt    = drop_cnt_o;
    timeout_nxt = timeout_cnt_o;

    case (state)
      ST_IDLE: begin
        state_nxt = ST_WAIT_LOCK;
        filt_nxt  = '0;
      end

      ST_WAIT_LOCK: begin
        if (lock_s && !los_s) begin
          if (filt_cnt == FILT_LAST) begin
            state_nxt = ST_TX_RST;
            filt_nxt  = '0;
            tmr_nxt   = RST_LOAD;
          end else begin
            filt_nxt = filt_cnt + FILT_W'(1);
          end
        end else begin
          filt_nxt = '0;
        end
      end

      ST_TX_RST: begin
        if (!lock_s) begin
          state_nxt = ST_WAIT_LOCK;
          filt_nxt  = '0;
        end else if (tmr == '0) begin
          state_nxt = ST_RX_RST;
          tmr_nxt   = RST_LOAD;
        end else begin
          tmr_nxt = tmr - TMR_W'(1);
        end
      end

      ST_RX_RST: begin
        if (!lock_s) begin
          state_nxt = ST_WAIT_LOCK;
          filt_nxt  = '0;
        end else if (tmr == '0) begin
          state_nxt = ST_WAIT_RX;
          tmr_nxt   = TMO_LOAD;
        end else begin
          tmr_nxt = tmr - TMR_W'(1);
        end
      end

      ST_WAIT_RX: begin
        if (!lock_s) begin
          state_nxt = ST_WAIT_LOCK;
          filt_nxt  = '0;
        end else if (rdy_s) begin
          state_nxt = ST_UP;
        end else if (tmr == '0) begin
          state_nxt   = ST_RX_RST;
          tmr_nxt     = RST_LOAD;
          timeout_nxt = sat_inc(timeout_cnt_o);
        end else begin
          tmr_nxt = tmr - TMR_W'(1);
        end
      end

      ST_UP: begin
        // Lock loss wins over LOS/ready loss and counts only as a relock.
        if (!lock_s) begin
          state_nxt  = ST_WAIT_LOCK;
          filt_nxt   = '0;
          relock_nxt = sat_inc(relock_cnt_o);
        end else if (los_s || !rdy_s) begin
          state_nxt = ST_RX_RST;
          tmr_nxt   = RST_LOAD;
          drop_nxt  = sat_inc(drop_cnt_o);
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Decoded from the next state so the registered outputs move with state.
    tx_rst_nxt   = (state_nxt inside {ST_IDLE, ST_WAIT_LOCK, ST_TX_RST});
    rx_rst_nxt   = !(state_nxt inside {ST_WAIT_RX, ST_UP});
    user_rst_nxt = (state_nxt != ST_UP);
    link_up_nxt  = (state_nxt == ST_UP);
  end

  // State register with its filter and pulse/timeout timers.
  always_ff @(posedge clk_ik) begin
    if (!rstn_ir) begin
      state    <= ST_IDLE;
      filt_cnt <= '0;
      tmr      <= '0;
    end else begin
      state    <= state_nxt;
      filt_cnt <= filt_nxt;
      tmr      <= tmr_nxt;
    end
  end

  // Diagnostic event counters.
  always_ff @(posedge clk_ik) begin
    if (!rstn_ir) begin
      relock_cnt_o  <= '0;
      drop_cnt_o    <= '0;
      timeout_cnt_o <= '0;
    end else begin
      relock_cnt_o  <= relock_nxt;
      drop_cnt_o    <= drop_nxt;
      timeout_cnt_o <= timeout_nxt;
    end
  end

  // Registered reset and status outputs.
  always_ff @(posedge clk_ik) begin
    if (!rstn_ir) begin
      gbt_tx_reset_o <= 1'b1;
      gbt_rx_reset_o <= 1'b1;
      user_reset_o   <= 1'b1;
      link_up_o      <= 1'b0;
    end else begin
      gbt_tx_reset_o <= tx_rst_nxt;
      gbt_rx_reset_o <= rx_rst_nxt;
      user_reset_o   <= user_rst_nxt;
      link_up_o      <= link_up_nxt;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_mcoi_link_reset_sequencer.sv
// Bench for the link reset sequencer: directed bring-up/fault scenarios
// followed by random input segments, checked by a scoreboard fed from a
// cycle-based reference model of the sequencing rules.
`timescale 1ns/1ps
module tb_mcoi_link_reset_sequencer;

  localparam int LF   = 8;
  localparam int RC   = 4;
  localparam int TO   = 20;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;
  localparam int TW   = 7 + 3 * CW;

  logic          clk  = 1'b0;
  logic          rstn = 1'b0;
  logic          lock = 1'b1;
  logic          los  = 1'b0;
  logic          rdy  = 1'b0;
  logic          tx, rx, usr, lnk;
  logic [2:0]    st;
  logic [CW-1:0] rel, drp, tmo;
  logic [TW-1:0] dut_t;
  logic [TW-1:0] prev_t;

  always #5 clk = ~clk;

  mcoi_link_reset_sequencer #(
    .G_LOCK_FILTER (LF),
    .G_RST_CYCLES  (RC),
    .G_RX_TIMEOUT  (TO),
    .G_CNT_W       (CW)
  ) dut (
    .clk_ik         (clk),
    .rstn_ir        (rstn),
    .pll_locked_i   (lock),
    .los_i          (los),
    .rx_ready_i     (rdy),
    .gbt_tx_reset_o (tx),
    .gbt_rx_reset_o (rx),
    .user_reset_o   (usr),
    .link_up_o      (lnk),
    .state_o        (st),
    .relock_cnt_o   (rel),
    .drop_cnt_o     (drp),
    .timeout_cnt_o  (tmo)
  );

  assign dut_t = {st, tx, rx, usr, lnk, rel, drp, tmo};

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit mon_on = 1'b0;

  typedef struct {
    int cyc;
    int st;
    int rel;
    int drp;
    int tmo;
  } exp_t;
  exp_t sb_q[$];

  task automatic check(input string name, input longint act, input longint req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input int s, input int max_cyc, input string name, output int at);
    at = -1;
    for (int i = 0; i <= max_cyc; i++) begin
      @(negedge clk);
      if (st == 3'(s)) begin
        at = cyc;
        break;
      end
    end
    check({name, "_reached"}, (at >= 0), 1);
  endtask

  // Expected outputs for a state, from the state/output table.
  function automatic logic exp_tx(input int s);  return (s == 0 || s == 1 || s == 2); endfunction
  function automatic logic exp_rx(input int s);  return !(s == 4 || s == 5);          endfunction
  function automatic logic exp_usr(input int s); return (s != 5);                     endfunction
  function automatic logic exp_lnk(input int s); return (s == 5);                     endfunction

  // Reference model: inputs delayed two cycles, then the sequencing rules
  // with "cycles spent in state" and "qualifying run length" bookkeeping.
  int   m_st = 0, m_age = 0, m_run = 0, m_rel = 0, m_drp = 0, m_tmo = 0;
  int   p_st, p_rel, p_drp, p_tmo;
  logic l1 = 1'b1, l2 = 1'b1, s1 = 1'b0, s2 = 1'b0, r1 = 1'b0, r2 = 1'b0;
  logic ls, ss, rs;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      ls = l2; ss = s2; rs = r2;
      l2 = l1; s2 = s1; r2 = r1;
      l1 = lock; s1 = los; r1 = rdy;
      p_st = m_st; p_rel = m_rel; p_drp = m_drp; p_tmo = m_tmo;
      if (!rstn) begin
        m_st = 0; m_age = 0; m_run = 0;
        m_rel = 0; m_drp = 0; m_tmo = 0;
      end else begin
        case (m_st)
          0: m_st = 1;
          1: begin
            if (ls && !ss) m_run++;
            else m_run = 0;
            if (m_run == LF) m_st = 2;
          end
          2, 3: begin
            if (!ls) m_st = 1;
            else begin
              m_age++;
              if (m_age == RC) m_st = (m_st == 2) ? 3 : 4;
            end
          end
          4: begin
            if (!ls) m_st = 1;
            else if (rs) m_st = 5;
            else begin
              m_age++;
              if (m_age == TO) begin
                m_st = 3;
                if (m_tmo < CMAX) m_tmo++;
              end
            end
          end
          5: begin
            if (!ls) begin
              m_st = 1;
              if (m_rel < CMAX) m_rel++;
            end else if (ss || !rs) begin
              m_st = 3;
              if (m_drp < CMAX) m_drp++;
            end
          end
          default: m_st = 0;
        endcase
      end
      if (m_st != p_st) begin
        m_age = 0;
        m_run = 0;
      end
      if (m_st != p_st || m_rel != p_rel || m_drp != p_drp || m_tmo != p_tmo)
        sb_q.push_back('{cyc, m_st, m_rel, m_drp, m_tmo});
    end
  end

  // Monitor: every change of the DUT's visible outputs is one event.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_on && dut_t !== prev_t) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_change: got state %0d, expected no change (cycle %0d)", st, cyc);
        end else begin
          e = sb_q.pop_front();
          check("event_cycle", cyc, e.cyc);
          check("event_state", st, e.st);
          check("event_tx_reset", tx, exp_tx(e.st));
          check("event_rx_reset", rx, exp_rx(e.st));
          check("event_user_reset", usr, exp_usr(e.st));
          check("event_link_up", lnk, exp_lnk(e.st));
          check("event_relock_cnt", rel, e.rel);
          check("event_drop_cnt", drp, e.drp);
          check("event_timeout_cnt", tmo, e.tmo);
        end
        prev_t = dut_t;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, w, w2, t1, a, at;

    rstn = 1'b0; lock = 1'b1; los = 1'b0; rdy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", st, 0);
    check("reset_tx", tx, 1);
    check("reset_rx", rx, 1);
    check("reset_user", usr, 1);
    check("reset_link", lnk, 0);
    check("reset_cnts", {rel, drp, tmo}, 0);
    prev_t = dut_t;
    mon_on = 1'b1;

    // Nominal bring-up.
    step(); rstn = 1'b1; c0 = cyc;
    wait_state(3, 20, "nom_rx_rst", at);
    check("nom_tx_fall_delay", at - c0, 13);
    check("nom_tx_low", tx, 0);
    wait_state(4, 10, "nom_wait_rx", w);
    check("nom_rx_fall_delay", w - c0, 17);
    check("nom_rx_low", rx, 0);
    repeat (5) step();
    rdy = 1'b1; a = cyc;
    wait_state(5, 3, "nom_up", at);
    check("nom_up_latency_le3", (at - a) <= 3, 1);
    check("nom_link_up", lnk, 1);
    check("nom_user_released", usr, 0);

    // RX ready never comes: periodic RX reset retries and saturating count.
    step(); rstn = 1'b0; rdy = 1'b0;
    step(); rstn = 1'b1;
    wait_state(4, 40, "tmo_wait_rx", w);
    wait_state(3, 25, "tmo_first", t1);
    check("tmo_first_delay", t1 - w, TO);
    wait_state(4, 10, "tmo_reentry", w2);
    check("tmo_period", w2 - w, TO + RC);
    while (cyc < w + 70) @(negedge clk);
    check("tmo_cnt_three", tmo, 3);
    while (cyc < w + 94) @(negedge clk);
    check("tmo_cnt_saturated", tmo, CMAX);
    check("tmo_state_rx_rst", st, 3);

    // Link drop on a 5-cycle LOS pulse.
    step(); rdy = 1'b1;
    wait_state(5, 20, "drop_up", at);
    step(); los = 1'b1; a = cyc;
    wait_state(3, 3, "drop_rx_rst", at);
    check("drop_latency_le3", (at - a) <= 3, 1);
    check("drop_link_down", lnk, 0);
    check("drop_cnt_one", drp, 1);
    check("drop_tx_stays_low", tx, 0);
    while (cyc < a + 5) step();
    los = 1'b0;
    wait_state(5, 20, "drop_recover", at);

    // Lock loss together with LOS: relock takes priority.
    step(); lock = 1'b0; los = 1'b1; a = cyc;
    wait_state(1, 3, "relock_wait_lock", at);
    check("relock_latency_le3", (at - a) <= 3, 1);
    check("relock_resets", {tx, rx, usr}, 3'b111);
    check("relock_cnt_one", rel, 1);
    check("relock_drop_unchanged", drp, 1);
    step(); lock = 1'b1; los = 1'b0;
    wait_state(5, 40, "relock_recover", at);

    // Reset pulse while waiting for RX ready.
    step(); rdy = 1'b0;
    wait_state(4, 20, "midrst_wait_rx", at);
    step(); rstn = 1'b0;
    step(); rstn = 1'b1; rdy = 1'b1;
    @(negedge clk);
    check("midrst_state", st, 0);
    check("midrst_resets", {tx, rx, usr, lnk}, 4'b1110);
    check("midrst_cnts", {rel, drp, tmo}, 0);
    wait_state(5, 60, "midrst_restart", at);

    // Single-cycle lock glitch part-way through the filter.
    step(); rstn = 1'b0;
    step(); rstn = 1'b1; c0 = cyc;
    while (cyc < c0 + 4) step();
    lock = 1'b0;
    step(); lock = 1'b1;
    wait_state(5, 80, "glitch_up", at);

    // Random segments.
    for (int seg = 0; seg < 150; seg++) begin
      step();
      if ($urandom_range(0, 29) == 0) begin
        rstn = 1'b0;
        step();
        rstn = 1'b1;
      end
      lock = ($urandom_range(0, 9) != 0);
      los  = ($urandom_range(0, 7) == 0);
      rdy  = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(1, 40)) step();
    end

    repeat (10) step();
    @(negedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
